// File: rtl/prog_ram_pkg.sv
// Shared types and helpers for the programmable multi-port RAM.
// PROG_RAM_WR_BYPASS_EN (see prog_ram_mp) selects write-through reads; nothing here depends on it.
package prog_ram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } prog_ram_state_t;

    function automatic int byte_count(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/prog_ram_clear_seq.sv
// Clear sequencer: owns the CLEAR/IDLE state, the sweep address and BUSY.
// Emits one zero-write per cycle while sweeping; the state is exported for the datapath and for debug.
module prog_ram_clear_seq
    import prog_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear_req,
    output prog_ram_state_t       state,
    output logic                  busy,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr
);

    prog_ram_state_t       state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        busy_d  = busy_q;
        case (state_q)
            CLEAR: begin
                addr_d = addr_q + 1'b1;
                // The last word of the sweep is written on the same edge we leave CLEAR.
                if (&addr_q) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            IDLE: begin
                if (clear_req) begin
                    state_d = CLEAR;
                    addr_d  = '0;
                    busy_d  = 1'b1;
                end
            end
            default: begin
                state_d = CLEAR;
                addr_d  = '0;
                busy_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            addr_q  <= '0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            busy_q  <= busy_d;
        end
    end

    assign state    = state_q;
    assign busy     = busy_q;
    assign clr_we   = (state_q == CLEAR) && !rst;
    assign clr_addr = addr_q;

endmodule

// File: rtl/prog_ram_mp.sv
// Multi-port RAM: one byte-masked write port, RD_PORTS registered read ports, built-in zeroing sweep.
// Define PROG_RAM_WR_BYPASS_EN for write-through reads on a same-edge address match; default is read-first.
module prog_ram_mp
    import prog_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3,
    parameter int RD_PORTS   = 2
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           CLEAR_REQ,
    input  logic                           WR_EN,
    input  logic [ADDR_WIDTH-1:0]          WR_ADDR,
    input  logic [DATA_WIDTH-1:0]          WR_DATA,
    input  logic [DATA_WIDTH/8-1:0]        BYTE_SELECT,
    input  logic [RD_PORTS*ADDR_WIDTH-1:0] RD_ADDR,
    output logic [RD_PORTS*DATA_WIDTH-1:0] RD_DATA,
    output logic                           BUSY
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int BYTES = byte_count(DATA_WIDTH);

    prog_ram_state_t       state;
    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;

    prog_ram_clear_seq #(.ADDR_WIDTH(ADDR_WIDTH)) u_clear_seq (
        .clk       (CLK),
        .rst       (RST),
        .clear_req (CLEAR_REQ),
        .state     (state),
        .busy      (BUSY),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr)
    );

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  user_we;
    logic [DATA_WIDTH-1:0] merged;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    // A clear request in IDLE takes priority over a same-cycle user write.
    assign user_we = (state == IDLE) && !RST && !CLEAR_REQ && WR_EN && (|BYTE_SELECT);

    always_comb begin
        merged = mem_q[WR_ADDR];
        for (int i = 0; i < BYTES; i++) begin
            if (BYTE_SELECT[i]) merged[8*i +: 8] = WR_DATA[8*i +: 8];
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = WR_ADDR;
        mem_wdata = merged;
        if (clr_we) begin
            mem_we    = 1'b1;
            mem_waddr = clr_addr;
            mem_wdata = '0;
        end else if (user_we) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    end

    for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
        logic [ADDR_WIDTH-1:0] rd_addr;
        logic [DATA_WIDTH-1:0] rd_d, rd_q;

        assign rd_addr = RD_ADDR[p*ADDR_WIDTH +: ADDR_WIDTH];

        always_comb begin
            rd_d = '0;
            if (state == IDLE) begin
                rd_d = mem_q[rd_addr];
`ifdef PROG_RAM_WR_BYPASS_EN
                if (user_we && (WR_ADDR == rd_addr)) rd_d = merged;
`endif
            end
        end

        always_ff @(posedge CLK) begin
            if (RST) rd_q <= '0;
            else     rd_q <= rd_d;
        end

        assign RD_DATA[p*DATA_WIDTH +: DATA_WIDTH] = rd_q;
    end

endmodule

// File: tb/tb_prog_ram_mp.sv
// Directed bench for prog_ram_mp (default parameters); read responses are checked through an expected queue.
// Build with PROG_RAM_WR_BYPASS_EN defined to exercise the write-through variant.
module tb_prog_ram_mp;

    logic        clk;
    logic        rst;
    logic        clear_req;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  byte_sel;
    logic [5:0]  rd_addr;
    logic [63:0] rd_data;
    logic        busy;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] exp_q[$];
    logic [63:0] mon_exp;
    logic        rd_chk = 1'b0;
    logic        chk_pipe = 1'b0;

    prog_ram_mp #(.DATA_WIDTH(32), .ADDR_WIDTH(3), .RD_PORTS(2)) dut (
        .CLK         (clk),
        .RST         (rst),
        .CLEAR_REQ   (clear_req),
        .WR_EN       (wr_en),
        .WR_ADDR     (wr_addr),
        .WR_DATA     (wr_data),
        .BYTE_SELECT (byte_sel),
        .RD_ADDR     (rd_addr),
        .RD_DATA     (rd_data),
        .BUSY        (busy)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endfunction

    // Monitor: a read presented before edge n is compared at the negedge after edge n.
    always @(posedge clk) chk_pipe <= rd_chk;

    always @(negedge clk) begin
        if (chk_pipe) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL rd_unexpected actual=%h required=none", rd_data);
            end else begin
                mon_exp = exp_q.pop_front();
                check("rd_data", rd_data, mon_exp);
            end
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
        wr_en     = 1'b0;
        clear_req = 1'b0;
        byte_sel  = 4'h0;
        rd_chk    = 1'b0;
    endtask

    task automatic do_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] m);
        wr_en = 1'b1; wr_addr = a; wr_data = d; byte_sel = m;
        tick();
    endtask

    task automatic do_read(input logic [2:0] a0, input logic [2:0] a1,
                           input logic [31:0] e0, input logic [31:0] e1);
        rd_addr = {a1, a0};
        rd_chk  = 1'b1;
        exp_q.push_back({e1, e0});
        tick();
    endtask

    task automatic do_wr_rd(input logic [2:0] wa, input logic [31:0] d, input logic [3:0] m,
                            input logic [2:0] a0, input logic [2:0] a1,
                            input logic [31:0] e0, input logic [31:0] e1);
        wr_en = 1'b1; wr_addr = wa; wr_data = d; byte_sel = m;
        rd_addr = {a1, a0};
        rd_chk  = 1'b1;
        exp_q.push_back({e1, e0});
        tick();
    endtask

    // Counts BUSY cycles while hammering ignored writes; every edge in the sweep must leave RD_DATA at 0.
    task automatic run_busy(input string name);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 20) begin
            wr_en = 1'b1; wr_addr = n[2:0]; wr_data = 32'h5555_5555; byte_sel = 4'hF;
            tick();
            n++;
            check({name, "_rd_zero"}, rd_data, 64'h0);
        end
        check({name, "_busy_len"}, 64'(n), 64'd8);
    endtask

    initial begin
        logic [31:0] rdw_exp;
        rst = 1'b1; clear_req = 1'b0; wr_en = 1'b0; wr_addr = '0;
        wr_data = '0; byte_sel = '0; rd_addr = '0;

        // Reset sweep
        repeat (3) begin
            tick();
            check("reset_busy", 64'(busy), 64'd1);
            check("reset_rd", rd_data, 64'h0);
        end
        rst = 1'b0;
        run_busy("reset");
        for (int k = 0; k < 8; k++) do_read(3'(k), 3'(7 - k), 32'h0, 32'h0);

        // Byte mask merge
        do_write(3'd5, 32'hAABB_CCDD, 4'hF);
        do_write(3'd5, 32'h1122_3344, 4'h5);
        do_read(3'd5, 3'd5, 32'hAA22_CC44, 32'hAA22_CC44);
        do_write(3'd5, 32'hFFFF_FFFF, 4'h0);
        do_read(3'd5, 3'd5, 32'hAA22_CC44, 32'hAA22_CC44);

        // Read during write
`ifdef PROG_RAM_WR_BYPASS_EN
        rdw_exp = 32'h0102_0304;
`else
        rdw_exp = 32'h0000_0000;
`endif
        do_wr_rd(3'd2, 32'h0102_0304, 4'hF, 3'd2, 3'd5, rdw_exp, 32'hAA22_CC44);
        do_read(3'd2, 3'd2, 32'h0102_0304, 32'h0102_0304);

        // Clear request beats a simultaneous write
        clear_req = 1'b1; wr_en = 1'b1; wr_addr = 3'd1; wr_data = 32'hDEAD_BEEF; byte_sel = 4'hF;
        tick();
        check("clr_busy_start", 64'(busy), 64'd1);
        run_busy("clr");
        do_read(3'd1, 3'd5, 32'h0, 32'h0);
        do_read(3'd2, 3'd0, 32'h0, 32'h0);

        // Dual-port independence
        for (int k = 0; k < 8; k++) do_write(3'(k), 32'(k) * 32'h0101_0101, 4'hF);
        for (int k = 0; k < 8; k++)
            do_read(3'(k), 3'(7 - k), 32'(k) * 32'h0101_0101, 32'(7 - k) * 32'h0101_0101);

        // Reset in the middle of a clear sweep
        clear_req = 1'b1;
        tick();
        repeat (4) tick();
        rst = 1'b1;
        repeat (2) begin
            tick();
            check("midrst_busy", 64'(busy), 64'd1);
            check("midrst_rd", rd_data, 64'h0);
        end
        rst = 1'b0;
        run_busy("midrst");
        for (int k = 0; k < 8; k++) do_read(3'(k), 3'(7 - k), 32'h0, 32'h0);

        // Post-clear write still works
        do_write(3'd6, 32'hCAFE_F00D, 4'hC);
        do_read(3'd6, 3'd7, 32'hCAFE_0000, 32'h0);

        tick();
        tick();
        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/prog_ram_mp.md
# prog_ram_mp

Parametrised multi-port programmable RAM: one byte-maskable write port and `RD_PORTS` independent registered read ports, all on a single clock. It adds a built-in clear sequencer that zeroes every word after reset or on request. It replaces the fixed 8×32 single-read RAM as the general storage primitive for register files, lookup tables and scratch memories in synthesised designs.

## Interface
- `DATA_WIDTH`, 32: word width in bits; must be a multiple of 8.
- `ADDR_WIDTH`, 3: address bits; `DEPTH` = 2^`ADDR_WIDTH` words.
- `RD_PORTS`, 2: number of read ports, ≥1.

Ports:
- `CLK`  in  1  sole clock; all state updates on the rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `CLEAR_REQ`  in  1  single-cycle request to zero the whole array.
- `WR_EN`  in  1  write strobe.
- `WR_ADDR`  in  `ADDR_WIDTH`  write address.
- `WR_DATA`  in  `DATA_WIDTH`  write data.
- `BYTE_SELECT`  in  `DATA_WIDTH`/8  per-byte write mask; bit i gates byte i.
- `RD_ADDR`  in  `RD_PORTS`×`ADDR_WIDTH`  packed read addresses; port p uses slice p.
- `RD_DATA`  out  `RD_PORTS`×`DATA_WIDTH`  packed registered read data.
- `BUSY`  out  1  clear sequence in progress.

## Operation
- FSM states: `CLEAR` and `IDLE`.
- `RST` high forces state `CLEAR`, clear address 0, `RD_DATA` all 0 and `BUSY` 1. It does not complete a sweep by itself.
- In `CLEAR`, each cycle with `RST` low:
  - writes 0 to the word at the clear address, then increments the address.
  - After writing word `DEPTH`-1, moves to `IDLE`.
- In `CLEAR`, user writes are dropped, `CLEAR_REQ` is ignored and `RD_DATA` is held at 0.
- In `IDLE`:
  - `CLEAR_REQ`=1 enters `CLEAR` at address 0.
  - A simultaneous `WR_EN` write is dropped; the clear wins.
- In `IDLE` with `WR_EN`=1: each byte i with `BYTE_SELECT`[i]=1 takes `WR_DATA` byte i. Unselected bytes keep their value. `BYTE_SELECT`=0 is a no-op.
- Read port p: in `IDLE`, `RD_DATA` slice p ← mem[`RD_ADDR` slice p] every cycle. There is no read enable. All ports may read the same address.
- Read-during-write to the same address follows the Configuration section.
- Address arithmetic is modulo `DEPTH`; no out-of-range case exists.

## Timing
- Read latency is 1 cycle: the address presented at edge n appears on `RD_DATA` after edge n.
- A write at edge n is visible to a read presented at edge n+1.
- `BUSY` is high while `RST` is high and for exactly `DEPTH` cycles after `RST` falls. It is also high for `DEPTH` cycles starting at the edge after a `CLEAR_REQ` accepted in `IDLE`.
- The first user write is accepted on the edge where `BUSY` is sampled 0.
- `RST` asserted mid-clear restarts the sweep at address 0. Total `BUSY` time is then `DEPTH` cycles measured from the `RST` release.
- `RD_DATA` becomes valid on the first edge after `BUSY` falls.
- Reset values: `RD_DATA`=0, `BUSY`=1.

## Configuration
- `PROG_RAM_WR_BYPASS_EN` defined: a read port addressing the word written at the same edge returns the merged new word. Selected bytes come from `WR_DATA`; unselected bytes keep their stored value.
- `PROG_RAM_WR_BYPASS_EN` undefined: that read returns the pre-write word (read-first).
- Clear behaviour and latency are identical either way.

## Structure
- Package `prog_ram_pkg`: state enum `prog_ram_state_t` (`CLEAR`, `IDLE`) and a function deriving the byte count from `DATA_WIDTH`.
- Submodule `prog_ram_clear_seq` holds the FSM, the clear-address counter and `BUSY`. It outputs the clear-write enable and clear address to the top level.
- The top level holds the array, the write-enable/address mux (clear vs user) and a generate loop over `RD_PORTS` for the read registers.

## Test plan
Defaults apply (32-bit, depth 8, 2 read ports).
- Reset sweep: `RST` high 3 cycles, then low → `BUSY` stays 1 for 8 cycles then falls. All 8 addresses read 0 on both ports.
- Byte mask: write 0xAABBCCDD to addr 5 with mask 0xF. Then write 0x11223344 to addr 5 with mask 0x5 → reads 0xAA22CC44 on both ports.
- Read-during-write: port 0 reads addr 2 while 0x01020304 is written to addr 2 with mask 0xF over old value 0x0. Response is 0x01020304 with `PROG_RAM_WR_BYPASS_EN`, else 0x00000000; the next cycle shows 0x01020304 either way.
- `CLEAR_REQ` together with a write of 0xDEADBEEF to addr 1 in `IDLE` → write dropped and `BUSY` high for 8 cycles. Writes during `BUSY` are ignored; afterwards addr 1 reads 0.
- Mid-clear reset: `RST` asserted at clear cycle 4 → `BUSY` is 1 for 8 cycles after release and all words read 0.
- Dual-port independence: fill addr k with k×0x01010101. Port 0 sweeps 0..7 and port 1 sweeps 7..0 → each port returns its own word with 1-cycle latency.
